m_fetch_buf: RTL and testbench

Instruction fetch buffer sitting directly upstream of the decode/register-read stage of the RV32 core. It generates sequential fetch addresses and issues them to a variable-latency instruction memory over a valid/ready request channel. It queues returned instruction words with their PCs in an in-order FIFO and hands them to decode over a valid/ready channel. A redirect from execute (branch/jump) flushes the queue and discards wrong-path responses still in flight.

---
 rtl/m_fetch_buf.sv | 107 ++++++++++
 tb/tb_m_fetch_buf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_fetch_buf.sv
// Instruction fetch buffer: issues sequential word fetches under a credit limit,
// queues in-order responses with their PCs, and flushes on redirect.
module m_fetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        w_imem_req_valid,
  input  logic        w_imem_req_ready,
  output logic [31:0] w_imem_req_addr,
  input  logic        w_imem_rsp_valid,
  input  logic [31:0] w_imem_rsp_data,
  output logic        w_inst_valid,
  input  logic        w_inst_ready,
  output logic [31:0] w_inst,
  output logic [31:0] w_inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic [CW:0]   credit_used;
  logic          accept;
  logic          rsp;
  logic          push;
  logic          pop;
  logic          drop_rsp;
  logic [31:0]   redirect_pc;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = &{1'b0, w_redirect_pc[1:0]};

  // Queued plus in-flight words may never exceed DEPTH, so a response always has a slot.
  assign credit_used      = {1'b0, occ_q} + {1'b0, out_q};
  assign w_imem_req_valid = !w_rst && (credit_used < (CW+1)'(DEPTH));
  assign w_imem_req_addr  = pc_q;
  assign w_inst_valid     = !w_rst && (occ_q != '0);
  assign w_inst           = inst_mem_q[rd_q];
  assign w_inst_pc        = pc_mem_q[rd_q];

  assign accept      = w_imem_req_valid && w_imem_req_ready;
  assign rsp         = w_imem_rsp_valid && !w_rst;
  assign drop_rsp    = rsp && (drop_q != '0);
  assign push        = rsp && (drop_q == '0) && !w_redirect;
  assign pop         = w_inst_valid && w_inst_ready && !w_redirect;
  assign redirect_pc = {w_redirect_pc[31:2], 2'b00};

  always_comb begin
    out_d    = out_q + CW'(accept) - CW'(rsp);
    pc_d     = accept ? pc_q + 32'd4 : pc_q;
    rsp_pc_d = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    drop_d   = drop_rsp ? drop_q - CW'(1) : drop_q;
    wr_d     = push ? wr_q + AW'(1) : wr_q;
    rd_d     = pop ? rd_q + AW'(1) : rd_q;
    occ_d    = occ_q + CW'(push) - CW'(pop);
    // Everything still outstanding after this cycle, including a fresh accept, is wrong-path.
    if (w_redirect) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = out_d;
      occ_d    = '0;
      rd_d     = '0;
      wr_d     = '0;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      occ_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      occ_q    <= occ_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  always_ff @(posedge w_clk) begin
    if (push) begin
      inst_mem_q[wr_q] <= w_imem_rsp_data;
      pc_mem_q[wr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_m_fetch_buf.sv
// Bench for m_fetch_buf: directed cycle table, corner-case sequences and random traffic
// against a queue-based reference model and an in-order variable-latency memory.
module tb_m_fetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        w_clk;
  logic        w_rst;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_imem_req_valid;
  logic        w_imem_req_ready;
  logic [31:0] w_imem_req_addr;
  logic        w_imem_rsp_valid;
  logic [31:0] w_imem_rsp_data;
  logic        w_inst_valid;
  logic        w_inst_ready;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;

  m_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .w_clk            (w_clk),
    .w_rst            (w_rst),
    .w_redirect       (w_redirect),
    .w_redirect_pc    (w_redirect_pc),
    .w_imem_req_valid (w_imem_req_valid),
    .w_imem_req_ready (w_imem_req_ready),
    .w_imem_req_addr  (w_imem_req_addr),
    .w_imem_rsp_valid (w_imem_rsp_valid),
    .w_imem_rsp_data  (w_imem_rsp_data),
    .w_inst_valid     (w_inst_valid),
    .w_inst_ready     (w_inst_ready),
    .w_inst           (w_inst),
    .w_inst_pc        (w_inst_pc)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // memory environment
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t memq[$];
  int    cyc      = 0;
  int    last_due = 0;
  int    lat_min  = 1;
  int    lat_max  = 1;

  // reference model: expected queue contents and in-flight requests tagged stale on redirect
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  logic [31:0] m_pc;
  logic [31:0] m_fifo[$];
  fl_t         m_fl[$];

  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];

  bit          s_rv, s_iv;
  logic [31:0] s_addr, s_pc;

  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit rq_rdy, input bit i_rdy);
    bit  rsp_v, exp_rv, exp_iv, acc_dut, acc_m, pop_m;
    int  d;
    fl_t h;
    w_rst            = rst;
    w_redirect       = redir;
    w_redirect_pc    = rpc;
    w_imem_req_ready = rq_rdy;
    w_inst_ready     = i_rdy;
    rsp_v            = (memq.size() > 0) && (memq[0].due <= cyc);
    w_imem_rsp_valid = rsp_v;
    w_imem_rsp_data  = rsp_v ? word_at(memq[0].addr) : $urandom;
    #1;
    s_rv   = w_imem_req_valid;
    s_iv   = w_inst_valid;
    s_addr = w_imem_req_addr;
    s_pc   = w_inst_pc;
    exp_rv = !rst && ((m_fifo.size() + m_fl.size()) < DEPTH);
    exp_iv = !rst && (m_fifo.size() > 0);
    chk("req_valid", 32'(w_imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", w_imem_req_addr, m_pc);
    chk("inst_valid", 32'(w_inst_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("inst_pc", w_inst_pc, m_fifo[0]);
      chk("inst", w_inst, word_at(m_fifo[0]));
    end

    acc_dut = w_imem_req_valid && rq_rdy;
    if (rsp_v) memq.delete(0);
    if (acc_dut) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d < last_due) d = last_due;
      last_due = d;
      memq.push_back('{addr: w_imem_req_addr, due: d});
      acc_log.push_back(w_imem_req_addr);
    end
    if (w_inst_valid && i_rdy && !redir && !rst) del_log.push_back(w_inst_pc);
    if (rst) begin
      memq.delete();
      last_due = 0;
    end

    acc_m = exp_rv && rq_rdy;
    pop_m = exp_iv && i_rdy;
    if (rst) begin
      m_pc = RESET_PC;
      m_fifo.delete();
      m_fl.delete();
    end else begin
      if (pop_m && !redir) m_fifo.delete(0);
      if (rsp_v) begin
        chk("rsp_has_request", 32'(m_fl.size() != 0), 32'd1);
        if (m_fl.size() != 0) begin
          h = m_fl.pop_front();
          if (!h.stale && !redir) m_fifo.push_back(h.pc);
        end
      end
      if (acc_m) begin
        m_fl.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (redir) begin
        m_fifo.delete();
        foreach (m_fl[i]) m_fl[i].stale = 1'b1;
        m_pc = {rpc[31:2], 2'b00};
      end
    end
    cyc++;
    @(negedge w_clk);
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [31:0] log_at(input logic [31:0] q[$], input int k);
    return (k < q.size()) ? q[k] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int n_wrong;
    // 1-cycle memory, decode always ready, two redirects coinciding with response+accept
    tbl[0]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0,          1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h4,          1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h8,          1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'hC,          1'b1, 32'h4};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_0103,  1'b1, 32'h10,         1'b1, 32'h8};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h100,        1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h104,        1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h108,        1'b1, 32'h100};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h10C,        1'b1, 32'h104};
    tbl[10] = '{1'b0, 1'b1, 32'hFFFF_FFFC,  1'b1, 32'h110,        1'b1, 32'h108};
    tbl[11] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'hFFFF_FFFC,  1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0,          1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h4,          1'b1, 32'hFFFF_FFFC};
    tbl[14] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h8,          1'b1, 32'h0};

    w_rst = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0; w_imem_req_ready = 1'b0;
    w_imem_rsp_valid = 1'b0; w_imem_rsp_data = '0; w_inst_ready = 1'b0;
    m_pc = RESET_PC;
    @(negedge w_clk);

    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].redir, tbl[i].rpc, 1'b1, 1'b1);
      chk($sformatf("tbl%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), 32'(s_iv), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) chk($sformatf("tbl%0d_inst_pc", i), s_pc, tbl[i].e_pc);
    end

    // decode stalled: credit stops fetch at four words, then drain in order
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    acc_log.delete(); del_log.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_accepts", 32'(acc_log.size()), 32'd4);
    chk("stall_last_addr", log_at(acc_log, 3), 32'hC);
    chk("stall_req_valid", 32'(s_rv), 32'd0);
    chk("stall_head_valid", 32'(s_iv), 32'd1);
    chk("stall_head_pc", s_pc, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) chk($sformatf("drain_pc%0d", k), log_at(del_log, k), 32'(k * 4));
    chk("resume_addr", log_at(acc_log, 4), 32'h10);

    // 3-cycle memory, redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    del_log.delete();
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_wrong = 0;
    foreach (del_log[i]) if (del_log[i] < 32'h100) n_wrong++;
    chk("lat3_wrongpath_delivered", 32'(n_wrong), 32'd0);
    chk("lat3_first_pc", log_at(del_log, 0), 32'h100);
    chk("lat3_second_pc", log_at(del_log, 1), 32'h104);

    // reset with queued and in-flight words
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("prerst_head_valid", 32'(s_iv), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("rst_inst_valid", 32'(s_iv), 32'd0);
    chk("rst_req_valid", 32'(s_rv), 32'd0);
    acc_log.delete(); del_log.delete();
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("postrst_inst_valid", 32'(s_iv), 32'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("postrst_first_addr", log_at(acc_log, 0), RESET_PC);
    chk("postrst_first_pc", log_at(del_log, 0), RESET_PC);
    chk("postrst_second_pc", log_at(del_log, 1), RESET_PC + 32'd4);

    // random traffic
    for (int blk = 0; blk < 15; blk++) begin
      lat_min = 1;
      lat_max = $urandom_range(4, 1);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(199, 0) == 0,
             $urandom_range(19, 0) == 0,
             $urandom,
             $urandom_range(3, 0) != 0,
             $urandom_range(9, 0) < 7);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
